// File: rtl/serial_sub_4bits_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: state encoding and
// bit-counter sizing.
package serial_sub_4bits_pkg;

   localparam int unsigned SUB_WIDTH = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      DONE  = ST_DONE
   } state_e;

   // Counter must be able to represent WIDTH itself.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

   localparam int unsigned CNT_W = cnt_width(SUB_WIDTH);

endpackage

// File: rtl/serial_sub_4bits_if.sv
// Start/busy/done handshake and operand/result bus for the serial subtractor.
interface serial_sub_4bits_if #(parameter int WIDTH = 4);

   logic             enable;
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Bin;
   logic             busy;
   logic             done;
   logic [WIDTH:0]   D;

   modport master (output enable, start, A, B, Bin, input busy, done, D);
   modport slave  (input enable, start, A, B, Bin, output busy, done, D);

endinterface

// File: rtl/serial_sub_4bits_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the step borrows.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_4bits.sv
// Bit-serial ripple-borrow subtractor, LSB first, result {borrow, diff}.
//   state | meaning
//   IDLE  | waiting for enable&start, D holds last result
//   SHIFT | one full-subtractor step per enabled edge
//   DONE  | done pulse visible, back to IDLE on next enabled edge
module serial_sub_4bits
   import serial_sub_4bits_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   serial_sub_4bits_if.slave bus
);

   localparam int CW = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             br_q, br_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH:0]   d_q, d_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             fs_diff;
   logic             fs_bout;

   full_subtractor u_fs (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .bin  (br_q),
      .d    (fs_diff),
      .bout (fs_bout)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      br_d    = br_q;
      res_d   = res_q;
      d_d     = d_q;
      busy_d  = busy_q;
      done_d  = done_q;
      if (bus.enable) begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  a_d     = bus.A;
                  b_d     = bus.B;
                  br_d    = bus.Bin;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               res_d = {fs_diff, res_q[WIDTH-1:1]};
               a_d   = a_q >> 1;
               b_d   = b_q >> 1;
               br_d  = fs_bout;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  d_d     = {fs_bout, fs_diff, res_q[WIDTH-1:1]};
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
            DONE: begin
               done_d  = 1'b0;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         br_q    <= 1'b0;
         res_q   <= '0;
         d_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         br_q    <= br_d;
         res_q   <= res_d;
         d_q     <= d_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.D    = d_q;

endmodule

// File: tb/tb_serial_sub_4bits.sv
// Randomized bench for serial_sub_4bits against an edge-timeline arithmetic model.
module tb_serial_sub_4bits;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   serial_sub_4bits_if #(.WIDTH(W)) bus ();

   serial_sub_4bits #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #10 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Model: indices count enabled edges; an accepted op at edge k is busy
   // for edges k..k+W-1, pulses done at k+W, next accept from k+W+2.
   int         ecount = 0;
   int         last_e = -1;
   int         acc_e  = 0;
   int         free_e = 0;
   bit         have_acc = 1'b0;
   logic [W:0] exp_res = '0;
   logic [W:0] exp_d   = '0;
   int         n_acc   = 0;
   int         n_done  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      have_acc = 1'b0;
      exp_d    = '0;
      free_e   = ecount;
      last_e   = ecount - 1;
   endtask

   task automatic step(input bit en, input bit st, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit bin);
      int  e;
      bit  exp_busy, exp_done;
      @(negedge clk);
      bus.enable = en;
      bus.start  = st;
      bus.A      = a;
      bus.B      = b;
      bus.Bin    = bin;
      @(posedge clk);
      if (en) begin
         e = ecount;
         ecount++;
         if (st && e >= free_e) begin
            acc_e    = e;
            have_acc = 1'b1;
            exp_res  = ({1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin});
            free_e   = e + W + 2;
            n_acc++;
         end
         last_e = e;
         if (have_acc && last_e == acc_e + W) exp_d = exp_res;
      end
      #1;
      exp_busy = have_acc && (last_e >= acc_e) && (last_e < acc_e + W);
      exp_done = have_acc && (last_e == acc_e + W);
      chk("busy", bus.busy, exp_busy);
      chk("done", bus.done, exp_done);
      chk("D", bus.D, exp_d);
      if (en && bus.done) n_done++;
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit bin);
      step(1'b1, 1'b1, a, b, bin);
      repeat (W) step(1'b1, 1'b0, W'($urandom), W'($urandom), 1'($urandom));
   endtask

   initial begin
      int d0, a0, guard;
      logic [W-1:0] ra, rb;
      bit rbin;
      bus.enable = 1'b0;
      bus.start  = 1'b0;
      bus.A      = '0;
      bus.B      = '0;
      bus.Bin    = 1'b0;
      #3;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_D", bus.D, 0);
      #22 rst = 1'b0;
      model_reset();

      // directed arithmetic with constant results
      run_op(4'b0111, 4'b0101, 1'b0);
      chk("t1_D", bus.D, 5'b00010);
      chk("t1_done", bus.done, 1);
      step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      chk("t1_hold", bus.D, 5'b00010);
      run_op(4'b0001, 4'b0101, 1'b0);
      chk("t2a_D", bus.D, 5'b11100);
      step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      run_op(4'b1000, 4'b1000, 1'b1);
      chk("t2b_D", bus.D, 5'b11111);
      step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      run_op(4'b1111, 4'b0000, 1'b0);
      chk("t2c_D", bus.D, 5'b01111);
      step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      run_op(4'b0000, 4'b1111, 1'b1);
      chk("wrap_D", bus.D, 5'b10000);
      step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);

      // enable gap and a start while busy
      d0 = n_done;
      step(1'b1, 1'b1, 4'b1001, 4'b1010, 1'b1);
      step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
      step(1'b0, 1'b1, 4'h3, 4'h1, 1'b0);
      step(1'b1, 1'b1, 4'h3, 4'h1, 1'b0);
      step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      chk("t3_early", bus.done, 0);
      step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      chk("t3_done6", bus.done, 1);
      chk("t3_D", bus.D, 5'b11110);
      repeat (4) step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      chk("t3_ndone", n_done - d0, 1);

      // async reset mid-operation
      step(1'b1, 1'b1, 4'b0111, 4'b0101, 1'b0);
      step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("t4_busy", bus.busy, 0);
      chk("t4_done", bus.done, 0);
      chk("t4_D", bus.D, 0);
      model_reset();
      #2 rst = 1'b0;
      run_op(4'b1100, 4'b0100, 1'b0);
      chk("t4_D2", bus.D, 5'b01000);
      step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);

      // start held high: back-to-back results every W+2 edges
      d0 = n_done;
      repeat (3 * (W + 2)) step(1'b1, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
      chk("t5_ndone", n_done - d0, 3);
      repeat (W + 2) step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);

      // exhaustive sweep with random enable gaps
      a0 = n_acc;
      d0 = n_done;
      for (int i = 0; i < 512; i++) begin
         ra    = W'(i);
         rb    = W'(i >> 4);
         rbin  = 1'(i >> 8);
         guard = 0;
         while (n_acc == a0 + i && guard < 40) begin
            step(($urandom_range(0, 3) != 0), 1'b1, ra, rb, rbin);
            guard++;
         end
         while (ecount < free_e && guard < 120) begin
            step(($urandom_range(0, 3) != 0), 1'b0, W'($urandom), W'($urandom), 1'($urandom));
            guard++;
         end
         if (guard >= 40 && n_acc == a0 + i) chk("t6_accept_timeout", guard, 0);
         if (guard >= 120) chk("t6_drain_timeout", guard, 0);
      end
      chk("t6_nacc", n_acc - a0, 512);
      chk("t6_ndone", n_done - d0, 512);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
